// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
package fetch_pkg;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small FIFO of fetch entries with push/pop/flush; occupancy is tracked by count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               din,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: owns the fetch PC, captures returned words with their PC into a FIFO
// and presents them to decode; redirects flush the FIFO and retarget the fetch PC.
module instr_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic [31:0]                imem_addr_o,
    input  logic [31:0]                imem_instr_i,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [31:0]                instr_o,
    output logic [31:0]                pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CW = $clog2(DEPTH + 1);

    logic         pop, push, unused_lsb;
    logic [31:0]  fetch_pc;
    fetch_entry_t head;

    assign unused_lsb    = ^redirect_pc_i[1:0];
    assign instr_valid_o = count_o != '0;
    assign pop           = instr_valid_o & instr_ready_i;
    assign push          = ~redirect_i & ((count_o != CW'(DEPTH)) | pop);
    assign imem_addr_o   = fetch_pc;
    assign instr_o       = instr_valid_o ? head.instr : RV_NOP;
    assign pc_o          = instr_valid_o ? head.pc : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_pc <= RESET_PC;
        else if (redirect_i) fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        else if (push) fetch_pc <= fetch_pc + 32'd4;
    end

    // the head consumed in a redirect cycle is squashed by decode; flush wins inside the FIFO
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(redirect_i),
        .din  ('{pc: fetch_pc, instr: imem_instr_i}),
        .head (head),
        .count(count_o)
    );
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: directed table, async reset, wrap scoreboard and random run vs a queue model.
module tb_instr_prefetch_buffer;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 0, rst = 1, redirect_i = 0, instr_ready_i = 0;
    logic [31:0]   redirect_pc_i = 0;
    logic [31:0]   imem_addr_o, imem_instr_i, instr_o, pc_o;
    logic          instr_valid_o;
    logic [CW-1:0] count_o;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_addr_o(imem_addr_o), .imem_instr_i(imem_instr_i), .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i), .instr_o(instr_o), .pc_o(pc_o), .count_o(count_o)
    );

    assign imem_instr_i = imem_addr_o ^ KEY;
    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
    ent_t q[$];
    logic [31:0] m_pc;

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        int          cnt;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic rd, input logic [31:0] rpc, input logic rdy);
        bit popped, can;
        if (rd) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            popped = q.size() > 0 && rdy;
            can = q.size() < DEPTH || popped;
            if (popped) void'(q.pop_front());
            if (can) begin
                q.push_back('{m_pc, m_pc ^ KEY});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".count"}, 32'(count_o), q.size());
        chk({tag, ".addr"}, imem_addr_o, m_pc);
        chk({tag, ".valid"}, 32'(instr_valid_o), 32'(q.size() > 0));
        chk({tag, ".instr"}, instr_o, q.size() > 0 ? q[0].instr : NOP);
        chk({tag, ".pc"}, pc_o, q.size() > 0 ? q[0].pc : 32'h0);
    endtask

    task automatic cycle(input logic rd, input logic [31:0] rpc, input logic rdy);
        redirect_i = rd;
        redirect_pc_i = rpc;
        instr_ready_i = rdy;
        model_step(rd, rpc, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rd, input logic [31:0] rpc, input logic rdy, input int cnt,
                       input logic [31:0] addr, input logic vld, input logic [31:0] pc);
        vecs.push_back('{rd, rpc, rdy, cnt, addr, vld, pc});
    endtask

    logic [31:0] last_pc;
    bit have_last;

    initial begin
        for (int i = 0; i < 8; i++)
            add(0, 0, 0, i < 4 ? i + 1 : 4, i < 4 ? 32'(4 * (i + 1)) : 32'h10, 1, 32'h0);
        add(0, 0, 1, 4, 32'h14, 1, 32'h4);
        add(0, 0, 1, 4, 32'h18, 1, 32'h8);
        add(1, 32'h0000_0203, 1, 0, 32'h200, 0, 32'h0);
        add(0, 0, 1, 1, 32'h204, 1, 32'h200);
        add(0, 0, 1, 1, 32'h208, 1, 32'h204);
        add(0, 0, 0, 2, 32'h20C, 1, 32'h204);
        add(1, 32'h0000_0080, 1, 0, 32'h80, 0, 32'h0);
        add(1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 32'h0);
        add(0, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFFC);
        add(0, 0, 1, 1, 32'h4, 1, 32'h0);
        add(0, 0, 1, 1, 32'h8, 1, 32'h4);

        #2;
        chk("rst.count", 32'(count_o), 0);
        chk("rst.valid", 32'(instr_valid_o), 0);
        chk("rst.instr", instr_o, NOP);
        chk("rst.pc", pc_o, 0);
        chk("rst.addr", imem_addr_o, 0);
        @(posedge clk);
        #1;
        rst = 0;
        q.delete();
        m_pc = 0;

        foreach (vecs[i]) begin
            cycle(vecs[i].rd, vecs[i].rpc, vecs[i].rdy);
            chk($sformatf("vec%0d.count", i), 32'(count_o), vecs[i].cnt);
            chk($sformatf("vec%0d.addr", i), imem_addr_o, vecs[i].addr);
            chk($sformatf("vec%0d.valid", i), 32'(instr_valid_o), 32'(vecs[i].vld));
            chk($sformatf("vec%0d.instr", i), instr_o, vecs[i].vld ? vecs[i].pc ^ KEY : NOP);
            chk($sformatf("vec%0d.pc", i), pc_o, vecs[i].pc);
        end

        cycle(0, 0, 0);
        cycle(0, 0, 0);
        model_check("pre_rst");
        rst = 1;
        #1;
        chk("async_rst.count", 32'(count_o), 0);
        chk("async_rst.valid", 32'(instr_valid_o), 0);
        chk("async_rst.instr", instr_o, NOP);
        chk("async_rst.addr", imem_addr_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 0;
        q.delete();
        m_pc = 0;

        cycle(1, 32'hFFFF_FFF0, 0);
        have_last = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            if (instr_valid_o && i % 2 == 0) begin
                if (have_last) chk("wrap.seq", pc_o, last_pc + 32'd4);
                last_pc = pc_o;
                have_last = 1;
            end
            cycle(0, 0, i % 2 == 0);
            model_check("wrap");
        end

        for (int i = 0; i < 500; i++) begin
            logic rd;
            logic [31:0] rpc;
            rd = $urandom_range(0, 11) == 0;
            rpc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
            cycle(rd, rpc, $urandom_range(0, 2) != 0);
            model_check("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
